multicycle_divider: RTL and testbench
=====================================

Name: multicycle_divider

Overview:
- Sequential restoring divider for the RV64M DIV/DIVU/REM/REMU instructions. It is the inverse-direction counterpart of the combinational add/sub datapath: it divides by repeated trial subtraction.
- Sits beside the ALU in the execute stage. The control unit starts it with a one-cycle pulse and stalls on busy until done.
- Produces one bit of quotient per cycle, with fixed latency independent of operand values, except for the special cases.

Parameters:
- WORDSIZE, 64, operand and result width in bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request. Sampled only in IDLE.
- op  input  2  operation code: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  WORDSIZE  numerator. Sampled on the start edge.
- divisor  input  WORDSIZE  denominator. Sampled on the start edge.
- busy  output  1  high from the start edge until the done pulse, inclusive.
- done  output  1  one-cycle pulse; result is valid in that same cycle.
- result  output  WORDSIZE  quotient or remainder as selected by op. Held until the next done.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, busy 0, done 0, result 0, internal registers 0.
  - Reset during an operation aborts it with no done pulse.
  - After release, the block accepts start on the first clock.
- States and transitions: IDLE -> PREP -> ITER -> FINISH -> IDLE.
- IDLE: on start=1, latch op, dividend and divisor; set busy=1; go to PREP. If start=0, stay.
- PREP (1 cycle):
  - Signed ops (DIV, REM) take absolute values and record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Unsigned ops use the operands as-is.
  - Clear the remainder accumulator, load the quotient shift register with |dividend|, load the count with WORDSIZE.
  - Detect special cases and go directly to FINISH on any of them; otherwise go to ITER.
- Divide by zero (divisor == 0):
  - Quotient = all ones (-1 for DIV, 2^WORDSIZE-1 for DIVU).
  - Remainder = original dividend.
- Signed overflow (DIV/REM only, dividend == 100..0, divisor == all ones):
  - Quotient = dividend.
  - Remainder = 0.
- ITER: exactly WORDSIZE cycles. Each cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem_shifted - |divisor|, computed at WORDSIZE+1 bits.
  - If trial is non-negative: rem = trial and quotient LSB = 1. Otherwise rem is kept and quotient LSB = 0.
  - Decrement count. When count reaches 1, go to FINISH.
- FINISH (1 cycle):
  - Apply signs: negate quotient if sign_q; negate remainder if sign_r (signed ops only).
  - Select quotient (DIV/DIVU) or remainder (REM/REMU) into result.
  - Assert done=1. Go to IDLE; busy drops at the next edge.
- Latency, counted from the start edge:
  - Normal operations: done is high in cycle WORDSIZE+2 (66 for the default).
  - Special cases: done is high in cycle 2.
- Handshake rules:
  - start while busy=1 is ignored, with no queueing.
  - start in the same cycle that done=1 is also ignored, because the state is not yet IDLE.
  - Operand inputs may change freely after the start edge.
- Width rules:
  - All arithmetic is two's complement, wrapping at WORDSIZE.
  - Negating the most negative value yields itself. This is correct for the magnitude path because the magnitude is treated as unsigned.

Decomposition:
- Shared package holds:
  - op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU);
  - state encodings (S_IDLE, S_PREP, S_ITER, S_FINISH);
  - the DIV_BY_ZERO_Q constant (all ones).
- One sub-module: the trial subtraction reuses the existing adder_sub with WORDSIZE+1 and operation=1. Its MSB gives the restore decision.
- Sign correction reuses the existing opposite module (two instances).

Test Plan:
- DIVU 100 / 7 -> done at cycle 66, result 14. REMU 100 / 7 -> result 2.
- DIV -7 / 2 -> result -3 (0xFFFF_FFFF_FFFF_FFFD). REM -7 / 2 -> result -1. DIV 7 / -2 -> result -3.
- DIVU 5 / 0 -> done at cycle 2, result 0xFFFF_FFFF_FFFF_FFFF. REM 5 / 0 -> result 5.
- DIV 0x8000_0000_0000_0000 / -1 -> done at cycle 2, result 0x8000_0000_0000_0000. REM same operands -> result 0.
- Pulse start again at cycle 10 with different operands during a DIVU 100/7 -> ignored: single done at cycle 66 with result 14. A back-to-back start one cycle after done is accepted.
- Assert reset_n low at cycle 30 mid-ITER -> busy, done and result go to 0 immediately with no done pulse. A new DIVU 9/3 after release returns 3.

Source files
------------

// File: rtl/multicycle_divider_pkg.sv
// Shared encodings and constants for the multicycle restoring divider.
package multicycle_divider_pkg;

  // Operation codes as presented on the op input.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  // Divider control states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_PREP   = 2'b01,
    S_ITER   = 2'b10,
    S_FINISH = 2'b11
  } state_e;

  // Widest operand this package's constants are sized for.
  localparam int unsigned MAX_WORDSIZE = 64;

  // Quotient returned on divide by zero: all ones (-1 signed, 2^N-1 unsigned).
  localparam logic [MAX_WORDSIZE-1:0] DIV_BY_ZERO_Q = {MAX_WORDSIZE{1'b1}};

  // Signed operations are DIV and REM.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Remainder-selecting operations are REM and REMU.
  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/adder_sub.sv
// Two's complement adder/subtractor: result = a + b, or a - b when operation_i is set.
module adder_sub #(
  parameter int unsigned WIDTH = 65
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             operation_i,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] carry_in_s;

  // Subtraction is a + ~b + 1; the +1 enters as the carry-in.
  assign b_eff_s    = b_i ^ {WIDTH{operation_i}};
  assign carry_in_s = {{(WIDTH-1){1'b0}}, operation_i};
  assign result_o   = a_i + b_eff_s + carry_in_s;

endmodule

// File: rtl/opposite.sv
// Two's complement negation. The most negative value maps onto itself.
module opposite #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = (~a_i) + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/multicycle_divider.sv
// Sequential restoring divider for RV64M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass
// the iteration and finish two cycles after start.
module multicycle_divider
  import multicycle_divider_pkg::*;
#(
  parameter int unsigned WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WORDSIZE-1:0] dividend,
  input  logic [WORDSIZE-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [WORDSIZE-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WORDSIZE + 1);
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(WORDSIZE);
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WORDSIZE-1:0] ZERO_W   = {WORDSIZE{1'b0}};
  localparam logic [WORDSIZE-1:0] ONES_W   = {WORDSIZE{1'b1}};
  localparam logic [WORDSIZE-1:0] MIN_NEG  = {1'b1, {(WORDSIZE-1){1'b0}}};

  // Registered state and its next-state values.
  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [WORDSIZE-1:0] dvd_q, dvd_d;
  logic [WORDSIZE-1:0] dvs_q, dvs_d;
  logic [WORDSIZE-1:0] dvs_abs_q, dvs_abs_d;
  logic [WORDSIZE-1:0] rem_q, rem_d;
  logic [WORDSIZE-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [WORDSIZE-1:0] result_q, result_d;

  // Combinational datapath.
  logic [WORDSIZE:0]   rem_shift_s;
  logic [WORDSIZE:0]   trial_s;
  logic [WORDSIZE-1:0] rem_step_s;
  logic [WORDSIZE-1:0] quo_step_s;
  logic [WORDSIZE-1:0] neg_a_in_s, neg_a_out_s;
  logic [WORDSIZE-1:0] neg_b_in_s, neg_b_out_s;
  logic [WORDSIZE-1:0] dvd_abs_s, dvs_abs_s;
  logic [WORDSIZE-1:0] quo_final_s, rem_final_s;
  logic [WORDSIZE-1:0] special_res_s;
  logic                signed_op_s, rem_op_s;
  logic                div_zero_s, overflow_s;

  assign signed_op_s = op_is_signed(op_q);
  assign rem_op_s    = op_is_rem(op_q);

  // One restoring step: shift {rem, quo} left, try subtracting |divisor|.
  // The shifted remainder needs WORDSIZE+1 bits, so the trial does too and
  // its MSB is the borrow that decides whether to restore.
  assign rem_shift_s = {rem_q, quo_q[WORDSIZE-1]};

  adder_sub #(
    .WIDTH (WORDSIZE + 1)
  ) u_trial (
    .a_i         (rem_shift_s),
    .b_i         ({1'b0, dvs_abs_q}),
    .operation_i (1'b1),
    .result_o    (trial_s)
  );

  assign rem_step_s = trial_s[WORDSIZE] ? rem_shift_s[WORDSIZE-1:0] : trial_s[WORDSIZE-1:0];
  assign quo_step_s = {quo_q[WORDSIZE-2:0], ~trial_s[WORDSIZE]};

  // The two negators are shared: in PREP they form operand magnitudes,
  // otherwise they sign-correct the final quotient and remainder.
  assign neg_a_in_s = (state_q == S_PREP) ? dvd_q : quo_step_s;
  assign neg_b_in_s = (state_q == S_PREP) ? dvs_q : rem_step_s;

  opposite #(
    .WIDTH (WORDSIZE)
  ) u_neg_a (
    .a_i (neg_a_in_s),
    .y_o (neg_a_out_s)
  );

  opposite #(
    .WIDTH (WORDSIZE)
  ) u_neg_b (
    .a_i (neg_b_in_s),
    .y_o (neg_b_out_s)
  );

  assign dvd_abs_s = (signed_op_s && dvd_q[WORDSIZE-1]) ? neg_a_out_s : dvd_q;
  assign dvs_abs_s = (signed_op_s && dvs_q[WORDSIZE-1]) ? neg_b_out_s : dvs_q;

  assign quo_final_s = neg_quo_q ? neg_a_out_s : quo_step_s;
  assign rem_final_s = neg_rem_q ? neg_b_out_s : rem_step_s;

  // Special cases resolved without iterating.
  assign div_zero_s    = (dvs_q == ZERO_W);
  assign overflow_s    = signed_op_s && (dvd_q == MIN_NEG) && (dvs_q == ONES_W);
  assign special_res_s = div_zero_s ? (rem_op_s ? dvd_q : DIV_BY_ZERO_Q[WORDSIZE-1:0])
                                    : (rem_op_s ? ZERO_W : dvd_q);

  // Next-state and datapath update for each control state.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    dvs_abs_d = dvs_abs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          dvd_d   = dividend;
          dvs_d   = divisor;
          busy_d  = 1'b1;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PREP: begin
        dvs_abs_d = dvs_abs_s;
        rem_d     = ZERO_W;
        quo_d     = dvd_abs_s;
        cnt_d     = CNT_LOAD;
        neg_quo_d = signed_op_s & (dvd_q[WORDSIZE-1] ^ dvs_q[WORDSIZE-1]);
        neg_rem_d = signed_op_s & dvd_q[WORDSIZE-1];
        if (div_zero_s || overflow_s) begin
          result_d = special_res_s;
          done_d   = 1'b1;
          state_d  = S_FINISH;
        end else begin
          state_d  = S_ITER;
        end
      end

      S_ITER: begin
        rem_d = rem_step_s;
        quo_d = quo_step_s;
        cnt_d = cnt_q - CNT_ONE;
        // Result is registered on the last step so it is valid with done.
        if (cnt_q == CNT_ONE) begin
          result_d = rem_op_s ? rem_final_s : quo_final_s;
          done_d   = 1'b1;
          state_d  = S_FINISH;
        end else begin
          state_d  = S_ITER;
        end
      end

      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= 2'b00;
      dvd_q     <= ZERO_W;
      dvs_q     <= ZERO_W;
      dvs_abs_q <= ZERO_W;
      rem_q     <= ZERO_W;
      quo_q     <= ZERO_W;
      cnt_q     <= {CNT_W{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= ZERO_W;
    end else begin
      op_q      <= op_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      dvs_abs_q <= dvs_abs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// Self-checking bench for multicycle_divider: scoreboard of expected
// results/latencies, one task per scenario.
module tb_multicycle_divider;

  localparam int LAT_NORMAL  = 66;
  localparam int LAT_SPECIAL = 2;
  localparam int LAT_BOUND   = 200;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  multicycle_divider #(
    .WORDSIZE (64)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model following RISC-V M-extension semantics.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = a;
    sb = b;
    if (b == 64'd0) return o[1] ? a : {64{1'b1}};
    if (!o[0] && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) return o[1] ? 64'd0 : a;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    if (b == 64'd0) return LAT_SPECIAL;
    if (!o[0] && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) return LAT_SPECIAL;
    return LAT_NORMAL;
  endfunction

  // Drive one start pulse, push the expectation, wait (bounded) for done.
  // lat counts clock edges with the start edge as 1.
  task automatic drive_and_wait(input string name, input logic [1:0] o,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] exp_res, input int exp_lat,
                                output int lat, output logic [63:0] res,
                                output logic bsy, output logic to);
    exp_t e;
    @(negedge clk);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.name = name;
    e.res  = exp_res;
    e.lat  = exp_lat;
    sb_q.push_back(e);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start    = 1'b0;
    op       = 2'b11;
    dividend = 64'hDEAD_BEEF_0BAD_F00D;
    divisor  = 64'd1;
    to  = 1'b1;
    res = 64'd0;
    bsy = 1'b0;
    for (int k = 0; k < LAT_BOUND; k++) begin
      if (done === 1'b1) begin
        res = result;
        bsy = busy;
        to  = 1'b0;
        break;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    dividend = 64'd0;
    divisor  = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (result !== 64'd0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
    reset_n = 1'b1;
  endtask

  task automatic test_arith();
    logic [1:0]  t_op [5];
    logic [63:0] t_a  [5];
    logic [63:0] t_b  [5];
    logic [63:0] t_r  [5];
    string       t_n  [5];
    exp_t        e;
    int          lat;
    logic [63:0] res;
    logic        bsy;
    logic        to;
    t_op = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00};
    t_a  = '{64'd100, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd7};
    t_b  = '{64'd7, 64'd7, 64'd2, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    t_r  = '{64'd14, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD};
    t_n  = '{"divu_100_7", "remu_100_7", "div_m7_2", "rem_m7_2", "div_7_m2"};
    for (int i = 0; i < 5; i++) begin
      drive_and_wait(t_n[i], t_op[i], t_a[i], t_b[i], t_r[i], LAT_NORMAL, lat, res, bsy, to);
      e = sb_q.pop_front();
      checks++;
      if (to !== 1'b0) begin
        failures++; $display("FAIL %s_timeout: no done within %0d cycles", e.name, LAT_BOUND);
      end else begin
        checks++;
        if (res !== e.res) begin failures++; $display("FAIL %s_result: got %h expected %h", e.name, res, e.res); end
        checks++;
        if (lat !== e.lat) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", e.name, lat, e.lat); end
        checks++;
        if (bsy !== 1'b1) begin failures++; $display("FAIL %s_busy_at_done: got %b expected 1", e.name, bsy); end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++; $display("FAIL %s_idle_after: busy=%b done=%b expected 0 0", e.name, busy, done);
      end
    end
  endtask

  task automatic test_special();
    logic [1:0]  t_op [6];
    logic [63:0] t_a  [6];
    logic [63:0] t_b  [6];
    logic [63:0] t_r  [6];
    string       t_n  [6];
    exp_t        e;
    int          lat;
    logic [63:0] res;
    logic        bsy;
    logic        to;
    t_op = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10};
    t_a  = '{64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB,
             64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    t_b  = '{64'd0, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    t_r  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB,
             64'h8000_0000_0000_0000, 64'd0};
    t_n  = '{"divu_5_0", "rem_5_0", "div_m5_0", "remu_m5_0", "div_ovf", "rem_ovf"};
    for (int i = 0; i < 6; i++) begin
      drive_and_wait(t_n[i], t_op[i], t_a[i], t_b[i], t_r[i], LAT_SPECIAL, lat, res, bsy, to);
      e = sb_q.pop_front();
      checks++;
      if (to !== 1'b0) begin
        failures++; $display("FAIL %s_timeout: no done within %0d cycles", e.name, LAT_BOUND);
      end else begin
        checks++;
        if (res !== e.res) begin failures++; $display("FAIL %s_result: got %h expected %h", e.name, res, e.res); end
        checks++;
        if (lat !== e.lat) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", e.name, lat, e.lat); end
      end
    end
  endtask

  // A second start mid-operation and a start during done are both dropped.
  task automatic test_ignored_start();
    exp_t        e;
    int          n;
    int          done_cnt;
    int          done_lat;
    logic [63:0] done_res;
    done_cnt = 0;
    done_lat = 0;
    done_res = 64'd0;
    @(negedge clk);
    op = 2'b01; dividend = 64'd100; divisor = 64'd7; start = 1'b1;
    e.name = "ignored_start"; e.res = 64'd14; e.lat = LAT_NORMAL;
    sb_q.push_back(e);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    while (n < 140) begin
      if (done === 1'b1) begin
        done_cnt++;
        done_lat = n;
        done_res = result;
        start = 1'b1; op = 2'b01; dividend = 64'd9; divisor = 64'd3;
      end else if (n == 9) begin
        start = 1'b1; op = 2'b00; dividend = 64'd1000; divisor = 64'd10;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL %s_done_count: got %0d expected 1", e.name, done_cnt); end
    checks++;
    if (done_lat !== e.lat) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", e.name, done_lat, e.lat); end
    checks++;
    if (done_res !== e.res) begin failures++; $display("FAIL %s_result: got %h expected %h", e.name, done_res, e.res); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s_idle_end: busy=%b expected 0", e.name, busy); end
  endtask

  // Second start arrives one cycle after the first done.
  task automatic test_back_to_back();
    logic [1:0]  t_op [2];
    logic [63:0] t_a  [2];
    logic [63:0] t_b  [2];
    logic [63:0] t_r  [2];
    string       t_n  [2];
    exp_t        e;
    int          lat;
    logic [63:0] res;
    logic        bsy;
    logic        to;
    t_op = '{2'b01, 2'b00};
    t_a  = '{64'd1000, 64'hFFFF_FFFF_FFFF_FF9C};
    t_b  = '{64'd10, 64'd7};
    t_r  = '{64'd100, 64'hFFFF_FFFF_FFFF_FFF2};
    t_n  = '{"b2b_first", "b2b_second"};
    for (int i = 0; i < 2; i++) begin
      drive_and_wait(t_n[i], t_op[i], t_a[i], t_b[i], t_r[i], LAT_NORMAL, lat, res, bsy, to);
      e = sb_q.pop_front();
      checks++;
      if (to !== 1'b0) begin
        failures++; $display("FAIL %s_timeout: no done within %0d cycles", e.name, LAT_BOUND);
      end else begin
        checks++;
        if (res !== e.res) begin failures++; $display("FAIL %s_result: got %h expected %h", e.name, res, e.res); end
        checks++;
        if (lat !== e.lat) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", e.name, lat, e.lat); end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t        e;
    int          n;
    int          lat;
    logic [63:0] res;
    logic        bsy;
    logic        to;
    logic        seen_done;
    @(negedge clk);
    op = 2'b01; dividend = 64'd100; divisor = 64'd7; start = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    while (n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midop_busy_before_reset: got %b expected 1", busy); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midop_reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL midop_reset_done: got %b expected 0", done); end
    checks++;
    if (result !== 64'd0) begin failures++; $display("FAIL midop_reset_result: got %h expected 0", result); end
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin failures++; $display("FAIL midop_done_in_reset: got %b expected 0", seen_done); end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    drive_and_wait("after_reset_divu_9_3", 2'b01, 64'd9, 64'd3, 64'd3, LAT_NORMAL, lat, res, bsy, to);
    e = sb_q.pop_front();
    checks++;
    if (to !== 1'b0) begin
      failures++; $display("FAIL %s_timeout: no done within %0d cycles", e.name, LAT_BOUND);
    end else begin
      checks++;
      if (res !== e.res) begin failures++; $display("FAIL %s_result: got %h expected %h", e.name, res, e.res); end
      checks++;
      if (lat !== e.lat) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", e.name, lat, e.lat); end
    end
  endtask

  task automatic test_random();
    exp_t        e;
    logic [1:0]  o;
    logic [63:0] a;
    logic [63:0] b;
    int          sel;
    int          lat;
    logic [63:0] res;
    logic        bsy;
    logic        to;
    for (int i = 0; i < 10; i++) begin
      o   = 2'($urandom_range(0, 3));
      a   = {$urandom, $urandom};
      sel = $urandom_range(0, 3);
      if (sel == 0) b = 64'd0;
      else if (sel == 1) b = 64'($urandom_range(1, 100));
      else if (sel == 2) b = -64'($urandom_range(1, 100));
      else b = {$urandom, $urandom} >> $urandom_range(0, 63);
      drive_and_wait($sformatf("rand%0d_op%0d", i, o), o, a, b, model(o, a, b), model_lat(o, a, b),
                     lat, res, bsy, to);
      e = sb_q.pop_front();
      checks++;
      if (to !== 1'b0) begin
        failures++; $display("FAIL %s_timeout: no done within %0d cycles", e.name, LAT_BOUND);
      end else begin
        checks++;
        if (res !== e.res) begin
          failures++; $display("FAIL %s_result: a=%h b=%h got %h expected %h", e.name, a, b, res, e.res);
        end
        checks++;
        if (lat !== e.lat) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", e.name, lat, e.lat); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
